// File: rtl/coor_mux_if.sv
// Coordinate bundle between the sources and coor_mux, plus the selected-target stream to servo_dri.
// master drives the source side; slave is the arbiter.
interface coor_mux_if #(
    parameter int CH_NUM = 2,
    parameter int COOR_W = 10,
    parameter int SEL_W  = 3
);
    logic [CH_NUM*COOR_W-1:0] ch_x;
    logic [CH_NUM*COOR_W-1:0] ch_y;
    logic [CH_NUM-1:0]        ch_valid;
    logic [1:0]               mode;
    logic [SEL_W-1:0]         force_sel;
    logic [COOR_W-1:0]        out_x;
    logic [COOR_W-1:0]        out_y;
    logic                     out_valid;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_lost;

    modport master (output ch_x, ch_y, ch_valid, mode, force_sel,
                    input  out_x, out_y, out_valid, out_ch, out_lost);
    modport slave  (input  ch_x, ch_y, ch_valid, mode, force_sel,
                    output out_x, out_y, out_valid, out_ch, out_lost);
endinterface

// File: rtl/coor_mux.sv
// N-channel target-coordinate arbiter with per-channel staleness, hold-through-dropout and default aim point.
// Define COOR_MUX_SMOOTH_EN to low-pass the tracked coordinate; otherwise it passes through.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_LOST  | no usable source, output parked at X_DEF/Y_DEF, out_lost=1
// S_TRACK | following the selected fresh channel
// S_HOLD  | selected source went stale, last output frozen for HOLD_CYC
module coor_mux #(
    parameter int                CH_NUM      = 2,
    parameter int                COOR_W      = 10,
    parameter int                SEL_W       = 3,
    parameter int                CNT_W       = 26,
    parameter int                TIMEOUT_CYC = 25_000_000,
    parameter int                HOLD_CYC    = 12_500_000,
    parameter logic [COOR_W-1:0] X_DEF       = COOR_W'(400),
    parameter logic [COOR_W-1:0] Y_DEF       = COOR_W'(240)
) (
    input  logic       clk,
    input  logic       rst_n,
    coor_mux_if.slave  bus
);

    localparam logic [CNT_W-1:0] AGE_MAX   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        S_LOST  = 2'd0,
        S_TRACK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    logic [COOR_W-1:0] lx_q  [CH_NUM];
    logic [COOR_W-1:0] ly_q  [CH_NUM];
    logic [CNT_W-1:0]  age_q [CH_NUM];
    logic [CH_NUM-1:0] upd_q;
    logic [CH_NUM-1:0] fresh;

    state_t            state_q;
    logic [CNT_W-1:0]  hold_cnt_q;
    logic [COOR_W-1:0] out_x_q;
    logic [COOR_W-1:0] out_y_q;
    logic              out_valid_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_lost_q;

    logic              sel_ok;
    logic [SEL_W-1:0]  sel_idx_d;
    logic [SEL_W-1:0]  fsel;
    logic [CNT_W-1:0]  best_age;
    logic [COOR_W-1:0] sel_x;
    logic [COOR_W-1:0] sel_y;
    logic              sel_upd;
    logic [COOR_W-1:0] trk_x_d;
    logic [COOR_W-1:0] trk_y_d;

    // upd_q delays each strobe by one cycle so the output update lines up with the latched data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                lx_q[i]  <= '0;
                ly_q[i]  <= '0;
                age_q[i] <= AGE_MAX;
            end
            upd_q <= '0;
        end else begin
            upd_q <= bus.ch_valid;
            for (int i = 0; i < CH_NUM; i++) begin
                if (bus.ch_valid[i]) begin
                    lx_q[i]  <= bus.ch_x[i*COOR_W +: COOR_W];
                    ly_q[i]  <= bus.ch_y[i*COOR_W +: COOR_W];
                    age_q[i] <= '0;
                end else if (age_q[i] != AGE_MAX) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        fresh = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            fresh[i] = (age_q[i] < AGE_MAX);
        end
    end

    // Out-of-range force_sel falls through to channel 0
    always_comb begin
        sel_ok    = 1'b0;
        sel_idx_d = '0;
        best_age  = '0;
        fsel      = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (int'(bus.force_sel) == i) fsel = SEL_W'(i);
        end
        case (bus.mode)
            2'd1: begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (fresh[i] && (!sel_ok || age_q[i] < best_age)) begin
                        sel_ok    = 1'b1;
                        sel_idx_d = SEL_W'(i);
                        best_age  = age_q[i];
                    end
                end
            end
            2'd2: begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (SEL_W'(i) == fsel && fresh[i]) begin
                        sel_ok    = 1'b1;
                        sel_idx_d = fsel;
                    end
                end
            end
            default: begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (fresh[i] && !sel_ok) begin
                        sel_ok    = 1'b1;
                        sel_idx_d = SEL_W'(i);
                    end
                end
            end
        endcase
        sel_x   = '0;
        sel_y   = '0;
        sel_upd = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (SEL_W'(i) == sel_idx_d) begin
                sel_x   = lx_q[i];
                sel_y   = ly_q[i];
                sel_upd = upd_q[i];
            end
        end
    end

`ifdef COOR_MUX_SMOOTH_EN
    logic [COOR_W+1:0] flt_x;
    logic [COOR_W+1:0] flt_y;

    always_comb begin
        flt_x   = ((COOR_W+2)'(3) * {2'b00, out_x_q} + {2'b00, sel_x} + (COOR_W+2)'(2)) >> 2;
        flt_y   = ((COOR_W+2)'(3) * {2'b00, out_y_q} + {2'b00, sel_y} + (COOR_W+2)'(2)) >> 2;
        trk_x_d = flt_x[COOR_W-1:0];
        trk_y_d = flt_y[COOR_W-1:0];
    end
`else
    always_comb begin
        trk_x_d = sel_x;
        trk_y_d = sel_y;
    end
`endif

    // Entering TRACK or switching channel always loads the raw latched sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOST;
            hold_cnt_q  <= '0;
            out_x_q     <= X_DEF;
            out_y_q     <= Y_DEF;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_lost_q  <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_TRACK: begin
                    if (!sel_ok) begin
                        state_q    <= S_HOLD;
                        hold_cnt_q <= '0;
                    end else if (sel_idx_d != out_ch_q) begin
                        out_ch_q    <= sel_idx_d;
                        out_x_q     <= sel_x;
                        out_y_q     <= sel_y;
                        out_valid_q <= 1'b1;
                    end else if (sel_upd) begin
                        out_x_q     <= trk_x_d;
                        out_y_q     <= trk_y_d;
                        out_valid_q <= 1'b1;
                    end
                end
                S_LOST, S_HOLD: begin
                    if (sel_ok) begin
                        state_q     <= S_TRACK;
                        out_lost_q  <= 1'b0;
                        out_ch_q    <= sel_idx_d;
                        out_x_q     <= sel_x;
                        out_y_q     <= sel_y;
                        out_valid_q <= 1'b1;
                    end else if (state_q == S_HOLD) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q     <= S_LOST;
                            out_lost_q  <= 1'b1;
                            out_x_q     <= X_DEF;
                            out_y_q     <= Y_DEF;
                            out_valid_q <= 1'b1;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= S_LOST;
                    out_lost_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_lost  = out_lost_q;

endmodule
